// File: rtl/cache_pkg.sv
// Shared encodings for the L2 snoop path: MESI states, snoop results, trace
// command codes, L1 message codes and the address field split.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int OFF_W  = 6;
  localparam int IDX_W  = 14;
  localparam int WAY_W  = 3;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    MESI_M = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b10,
    MESI_I = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    RES_NOHIT = 2'b00,
    RES_HIT   = 2'b01,
    RES_HITM  = 2'b10
  } snoop_res_t;

  typedef enum logic [3:0] {
    CMD_L1_READ     = 4'd0,
    CMD_L1_WRITE    = 4'd1,
    CMD_L1_IFETCH   = 4'd2,
    CMD_SNOOP_INV   = 4'd3,
    CMD_SNOOP_READ  = 4'd4,
    CMD_SNOOP_WRITE = 4'd5,
    CMD_SNOOP_RFO   = 4'd6,
    CMD_CLEAR       = 4'd8,
    CMD_PRINT       = 4'd9
  } cmd_t;

  typedef enum logic [1:0] {
    L1_GETLINE   = 2'b00,
    L1_INVLINE   = 2'b01,
    L1_EVICTLINE = 2'b10
  } l1_msg_t;

  typedef struct packed {
    snoop_res_t result;
    logic       need_get;
    logic       need_wb;
    logic       need_inv;
    l1_msg_t    inv_msg;
    mesi_t      new_state;
    logic       err;
  } snoop_action_t;

  function automatic logic is_snoop_cmd(input logic [3:0] c);
    return (c >= 4'd3) && (c <= 4'd6);
  endfunction

endpackage

// File: rtl/snoop_action_decode.sv
// Combinational MESI snoop action table: present state plus snooped command
// gives the bus result, the L1/writeback work to do and the next state.
module snoop_action_decode
  import cache_pkg::*;
(
  input  logic [1:0]    state,
  input  logic [3:0]    cmd,
  output snoop_action_t act
);

  always_comb begin
    act           = '0;
    act.result    = RES_NOHIT;
    act.inv_msg   = L1_INVLINE;
    act.new_state = mesi_t'(state);
    case (cmd_t'(cmd))
      CMD_SNOOP_READ: begin
        case (mesi_t'(state))
          MESI_M: begin
            act.result    = RES_HITM;
            act.need_get  = 1'b1;
            act.need_wb   = 1'b1;
            act.new_state = MESI_S;
          end
          MESI_E, MESI_S: begin
            act.result    = RES_HIT;
            act.new_state = MESI_S;
          end
          default: ;
        endcase
      end
      CMD_SNOOP_RFO: begin
        case (mesi_t'(state))
          MESI_M: begin
            act.result    = RES_HITM;
            act.need_get  = 1'b1;
            act.need_wb   = 1'b1;
            act.need_inv  = 1'b1;
            act.inv_msg   = L1_EVICTLINE;
            act.new_state = MESI_I;
          end
          MESI_E, MESI_S: begin
            act.result    = RES_HIT;
            act.need_inv  = 1'b1;
            act.new_state = MESI_I;
          end
          default: ;
        endcase
      end
      CMD_SNOOP_INV: begin
        case (mesi_t'(state))
          MESI_S: begin
            act.result    = RES_HIT;
            act.need_inv  = 1'b1;
            act.new_state = MESI_I;
          end
          // Another cache cannot be invalidating a line we hold exclusively.
          MESI_M, MESI_E: act.err = 1'b1;
          default: ;
        endcase
      end
      CMD_SNOOP_WRITE: begin
        if (mesi_t'(state) != MESI_I) act.err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cache_snoop_responder.sv
// Snoop responder FSM: captures a bus snoop, looks the line up, reports the
// snoop result at a fixed latency, then sequences L1 / writeback / state update.
module cache_snoop_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 6,
  parameter int IDX_W  = 14,
  parameter int WAY_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      snoop_valid,
  output logic                      snoop_ready,
  input  logic [3:0]                snoop_cmd,
  input  logic [ADDR_W-1:0]         snoop_addr,
  output logic                      lkp_req,
  output logic [IDX_W-1:0]          lkp_index,
  output logic [ADDR_W-IDX_W-OFF_W-1:0] lkp_tag,
  input  logic                      lkp_hit,
  input  logic [WAY_W-1:0]          lkp_way,
  input  logic [1:0]                lkp_state,
  output logic                      snoop_result_valid,
  output logic [1:0]                snoop_result,
  output logic                      l1_msg_valid,
  output logic [1:0]                l1_msg,
  input  logic                      l1_msg_ack,
  output logic                      wb_req,
  output logic [ADDR_W-1:0]         wb_addr,
  input  logic                      wb_ack,
  output logic                      upd_en,
  output logic [IDX_W-1:0]          upd_index,
  output logic [WAY_W-1:0]          upd_way,
  output logic [1:0]                upd_state,
  output logic                      protocol_err
);

  localparam int TW = ADDR_W - IDX_W - OFF_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_L1_GET = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_L1_INV = 3'd6;
  localparam logic [2:0] S_UPDATE = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [WAY_W-1:0]  way_q, way_d;
  snoop_action_t     act_q, act_d, act_dec;
  logic              upd_needed_q, upd_needed_d;
  logic              bad_cmd_q, bad_cmd_d;
  mesi_t             pres_state;
  logic [2:0]        after_inv, after_wb;

  // A miss is indistinguishable from a hit on an invalid way.
  assign pres_state = lkp_hit ? mesi_t'(lkp_state) : MESI_I;

  snoop_action_decode u_decode (
    .state (pres_state),
    .cmd   (cmd_q),
    .act   (act_dec)
  );

  assign after_inv = upd_needed_q ? S_UPDATE : S_IDLE;
  assign after_wb  = act_q.need_inv ? S_L1_INV : after_inv;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    way_d        = way_q;
    act_d        = act_q;
    upd_needed_d = upd_needed_q;
    bad_cmd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snoop_valid) begin
          if (is_snoop_cmd(snoop_cmd)) begin
            addr_d  = snoop_addr;
            cmd_d   = snoop_cmd;
            state_d = S_LOOKUP;
          end else begin
            bad_cmd_d = 1'b1;
          end
        end
      end
      S_LOOKUP: state_d = S_DECIDE;
      S_DECIDE: begin
        act_d        = act_dec;
        way_d        = lkp_way;
        upd_needed_d = (act_dec.new_state != pres_state);
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (act_q.need_get)      state_d = S_L1_GET;
        else if (act_q.need_inv) state_d = S_L1_INV;
        else                     state_d = after_inv;
      end
      S_L1_GET: if (l1_msg_ack) state_d = act_q.need_wb ? S_WB : after_wb;
      S_WB:     if (wb_ack)     state_d = after_wb;
      S_L1_INV: if (l1_msg_ack) state_d = after_inv;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cmd_q        <= '0;
      way_q        <= '0;
      act_q        <= '0;
      upd_needed_q <= 1'b0;
      bad_cmd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      way_q        <= way_d;
      act_q        <= act_d;
      upd_needed_q <= upd_needed_d;
      bad_cmd_q    <= bad_cmd_d;
    end
  end

  assign snoop_ready        = (state_q == S_IDLE);
  assign lkp_req            = (state_q == S_LOOKUP);
  assign lkp_index          = addr_q[OFF_W +: IDX_W];
  assign lkp_tag            = addr_q[ADDR_W-1 -: TW];
  assign snoop_result_valid = (state_q == S_RESP);
  assign snoop_result       = (state_q == S_RESP) ? act_q.result : RES_NOHIT;
  assign l1_msg_valid       = (state_q == S_L1_GET) || (state_q == S_L1_INV);
  assign l1_msg             = (state_q == S_L1_INV) ? act_q.inv_msg : L1_GETLINE;
  assign wb_req             = (state_q == S_WB);
  assign wb_addr            = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign upd_en             = (state_q == S_UPDATE);
  assign upd_index          = addr_q[OFF_W +: IDX_W];
  assign upd_way            = way_q;
  assign upd_state          = act_q.new_state;
  assign protocol_err       = bad_cmd_q || ((state_q == S_RESP) && act_q.err);

endmodule

// File: tb/tb_cache_snoop_responder.sv
// Bench for cache_snoop_responder: directed scenarios plus random snoops checked
// against a transaction-level MESI reference model.
module tb_cache_snoop_responder;

  localparam logic [1:0] M = 2'b00, E = 2'b01, S = 2'b10, I = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snoop_valid;
  logic        snoop_ready;
  logic [3:0]  snoop_cmd;
  logic [31:0] snoop_addr;
  logic        lkp_req;
  logic [13:0] lkp_index;
  logic [11:0] lkp_tag;
  logic        lkp_hit;
  logic [2:0]  lkp_way;
  logic [1:0]  lkp_state;
  logic        snoop_result_valid;
  logic [1:0]  snoop_result;
  logic        l1_msg_valid;
  logic [1:0]  l1_msg;
  logic        l1_msg_ack;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_ack;
  logic        upd_en;
  logic [13:0] upd_index;
  logic [2:0]  upd_way;
  logic [1:0]  upd_state;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;
  int ev_q[$];
  int exp_q[$];

  cache_snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
    .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
    .lkp_req(lkp_req), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
    .lkp_hit(lkp_hit), .lkp_way(lkp_way), .lkp_state(lkp_state),
    .snoop_result_valid(snoop_result_valid), .snoop_result(snoop_result),
    .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg), .l1_msg_ack(l1_msg_ack),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .upd_en(upd_en), .upd_index(upd_index), .upd_way(upd_way),
    .upd_state(upd_state), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: events are 'h10+L1 message, 'h20 writeback, 'h30+new state.
  task automatic model(input logic [3:0] cmd, input bit hit, input logic [1:0] st,
                       output int res, output bit err);
    logic [1:0] p;
    p = hit ? st : I;
    res = 0;
    err = 1'b0;
    exp_q.delete();
    if (cmd == 4) begin
      if (p == M) begin res = 2; exp_q = '{'h10, 'h20, 'h30 + S}; end
      else if (p == E) begin res = 1; exp_q = '{'h30 + S}; end
      else if (p == S) res = 1;
    end else if (cmd == 6) begin
      if (p == M) begin res = 2; exp_q = '{'h10, 'h20, 'h12, 'h30 + I}; end
      else if (p != I) begin res = 1; exp_q = '{'h11, 'h30 + I}; end
    end else if (cmd == 3) begin
      if (p == S) begin res = 1; exp_q = '{'h11, 'h30 + I}; end
      else if (p != I) err = 1'b1;
    end else if (cmd == 5) begin
      err = (p != I);
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] cmd, input logic [31:0] addr,
                        input bit hit, input logic [1:0] st, input logic [2:0] way, input int dly);
    int lkp_cnt, lkp_cyc, res_cnt, res_cyc, res_val, err_cnt, err_cyc, done, wl1, wwb;
    int exp_res, hs, upd, exp_done;
    bit exp_err, legal, lkp_prev;
    logic [1:0] held_msg;
    logic [31:0] held_wb;
    lkp_cnt = 0; lkp_cyc = -1; res_cnt = 0; res_cyc = -1; res_val = -1;
    err_cnt = 0; err_cyc = -1; done = -1; wl1 = 0; wwb = 0; lkp_prev = 1'b0;
    held_msg = '0; held_wb = '0;
    ev_q.delete();
    @(negedge clk);
    check({nm, ".ready_in"}, snoop_ready, 1);
    snoop_valid = 1'b1; snoop_cmd = cmd; snoop_addr = addr;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0; snoop_cmd = 4'($urandom); snoop_addr = $urandom;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      l1_msg_ack = 1'b0; wb_ack = 1'b0;
      if (c == 1) begin l1_msg_ack = 1'($urandom); wb_ack = 1'($urandom); end
      if (lkp_prev) begin
        lkp_hit = hit; lkp_state = st; lkp_way = way;
      end else begin
        lkp_hit = 1'($urandom); lkp_state = 2'($urandom); lkp_way = 3'($urandom);
      end
      lkp_prev = lkp_req;
      if (lkp_req) begin
        lkp_cnt++; lkp_cyc = c;
        check({nm, ".lkp_index"}, lkp_index, (addr >> 6) & 32'h3FFF);
        check({nm, ".lkp_tag"}, lkp_tag, addr >> 20);
      end
      if (snoop_result_valid) begin res_cnt++; res_cyc = c; res_val = snoop_result; end
      if (protocol_err) begin err_cnt++; err_cyc = c; end
      if (l1_msg_valid) begin
        if (wl1 > 0) check({nm, ".l1_held"}, l1_msg, held_msg);
        held_msg = l1_msg;
        if (wl1 == dly) begin l1_msg_ack = 1'b1; ev_q.push_back('h10 + l1_msg); wl1 = 0; end
        else wl1++;
      end
      if (wb_req) begin
        if (wwb > 0) check({nm, ".wb_held"}, wb_addr, held_wb);
        held_wb = wb_addr;
        if (wwb == dly) begin
          wb_ack = 1'b1; ev_q.push_back('h20); wwb = 0;
          check({nm, ".wb_addr"}, wb_addr, addr & ~32'h3F);
        end else wwb++;
      end
      if (upd_en) begin
        ev_q.push_back('h30 + upd_state);
        check({nm, ".upd_index"}, upd_index, (addr >> 6) & 32'h3FFF);
        check({nm, ".upd_way"}, upd_way, way);
      end
      if (snoop_ready) begin done = c; break; end
    end
    l1_msg_ack = 1'b0; wb_ack = 1'b0; lkp_hit = 1'b0;

    model(cmd, hit, st, exp_res, exp_err);
    legal = (cmd >= 3) && (cmd <= 6);
    hs = 0; upd = 0;
    foreach (exp_q[k]) if (exp_q[k] >= 'h30) upd = 1; else hs++;
    exp_done = legal ? 4 + hs * (dly + 1) + upd : 1;
    check({nm, ".lkp_cnt"}, lkp_cnt, legal);
    if (legal) begin
      check({nm, ".lkp_cyc"}, lkp_cyc, 1);
      check({nm, ".res_cyc"}, res_cyc, 3);
      check({nm, ".result"}, res_val, exp_res);
    end
    check({nm, ".res_cnt"}, res_cnt, legal);
    check({nm, ".err_cnt"}, err_cnt, exp_err);
    if (exp_err) check({nm, ".err_cyc"}, err_cyc, legal ? 3 : 1);
    check({nm, ".n_events"}, ev_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < ev_q.size(); k++)
      check({nm, ".event"}, ev_q[k], exp_q[k]);
    check({nm, ".ready_cyc"}, done, exp_done);
  endtask

  initial begin
    int seen, upd_seen, first_rdy, second_rdy, lkp_n;
    int lkp_cycs[$];
    logic [13:0] second_idx;
    rst_n = 1'b0; snoop_valid = 1'b0; snoop_cmd = '0; snoop_addr = '0;
    lkp_hit = 1'b0; lkp_way = '0; lkp_state = '0; l1_msg_ack = 1'b0; wb_ack = 1'b0;
    #1;
    check("reset.ready", snoop_ready, 1);
    check("reset.outs", {lkp_req, snoop_result_valid, snoop_result, l1_msg_valid, l1_msg,
                         wb_req, wb_addr, upd_en, upd_index, upd_way, upd_state, protocol_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a writeback.
    @(negedge clk);
    snoop_valid = 1'b1; snoop_cmd = 4'd6; snoop_addr = 32'h8000_00C0;
    @(posedge clk);
    #1 snoop_valid = 1'b0;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      lkp_hit = (c == 2); lkp_state = M; lkp_way = 3'd1;
      l1_msg_ack = l1_msg_valid;
      if (wb_req) begin seen = 1; break; end
    end
    l1_msg_ack = 1'b0;
    check("rstwb.wb_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwb.ready", snoop_ready, 1);
    check("rstwb.outs", {lkp_req, snoop_result_valid, snoop_result, l1_msg_valid, l1_msg,
                         wb_req, wb_addr, upd_en, upd_index, upd_way, upd_state, protocol_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    upd_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wb_ack = 1'b1;
      if (upd_en) upd_seen++;
    end
    wb_ack = 1'b0;
    check("rstwb.no_upd", upd_seen, 0);
    check("rstwb.ready_after", snoop_ready, 1);

    run_op("rd_E", 4'd4, 32'h0000_1040, 1'b1, E, 3'd5, 0);
    run_op("rfo_M", 4'd6, 32'h8000_00C0, 1'b1, M, 3'd2, 2);
    run_op("inv_miss", 4'd3, 32'h1234_5678, 1'b0, S, 3'd0, 0);
    run_op("inv_E", 4'd3, 32'h0BAD_F00D, 1'b1, E, 3'd3, 0);
    run_op("wr_S", 4'd5, 32'h0000_2FC0, 1'b1, S, 3'd4, 0);
    run_op("rd_M", 4'd4, 32'hFFFF_FFFF, 1'b1, M, 3'd7, 1);
    run_op("rfo_S", 4'd6, 32'h0004_0000, 1'b1, S, 3'd6, 3);
    run_op("bad9", 4'd9, 32'h0000_0040, 1'b1, S, 3'd0, 0);

    // Two queued misses with snoop_valid held high.
    @(negedge clk);
    snoop_valid = 1'b1; snoop_cmd = 4'd4; snoop_addr = 32'h0000_0100;
    @(posedge clk);
    #1 snoop_addr = 32'h0003_FFC0;
    first_rdy = -1; second_rdy = -1; second_idx = '0;
    lkp_cycs.delete();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5) snoop_valid = 1'b0;
      if (lkp_req) begin lkp_cycs.push_back(c); second_idx = lkp_index; end
      if (snoop_ready && first_rdy < 0) first_rdy = c;
      else if (snoop_ready && c > 4 && second_rdy < 0) second_rdy = c;
    end
    snoop_valid = 1'b0;
    lkp_n = lkp_cycs.size();
    check("b2b.first_ready", first_rdy, 4);
    check("b2b.lkp_count", lkp_n, 2);
    if (lkp_n == 2) check("b2b.second_lkp_cyc", lkp_cycs[1], 5);
    check("b2b.second_idx", second_idx, 14'h0FFF);
    check("b2b.second_ready", second_rdy, 8);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] cmd;
      cmd = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(3, 6));
      run_op("rand", cmd, $urandom, 1'($urandom), 2'($urandom), 3'($urandom),
             $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
